// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - operation selects, MIPS opcode/funct codes, FSM and format enums for instr_encoder
package enc_pkg;

  typedef enum logic [5:0] {
    ENC_ADD, ENC_ADDU, ENC_SUB, ENC_SUBU, ENC_MADD, ENC_MADDU, ENC_MUL,
    ENC_AND, ENC_OR, ENC_XOR, ENC_NOR, ENC_SLT,
    ENC_SLL, ENC_SRL, ENC_SRA, ENC_SLA, ENC_JR,
    ENC_ADDI, ENC_ADDIU, ENC_SLTI, ENC_SEQ, ENC_ANDI, ENC_ORI, ENC_XORI, ENC_LUI,
    ENC_LW, ENC_SW, ENC_BEQ, ENC_BNE, ENC_BGT, ENC_BGTE, ENC_BLE, ENC_BLEQ,
    ENC_BLEU, ENC_BGTU, ENC_J, ENC_JAL, ENC_HALT,
    ENC_LI, ENC_MOVE, ENC_NOP
  } op_t;

  typedef enum logic [1:0] {IDLE, OUT1, OUT2A} state_t;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_PSEUDO} fmt_t;

  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_ADDU  = 6'd33;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SUBU  = 6'd35;
  localparam logic [5:0] F_MADD  = 6'd28;
  localparam logic [5:0] F_MADDU = 6'd29;
  localparam logic [5:0] F_MUL   = 6'd30;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_SRA   = 6'd3;
  localparam logic [5:0] F_SLA   = 6'd4;
  localparam logic [5:0] F_JR    = 6'd8;

  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SEQ   = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BGT   = 6'd24;
  localparam logic [5:0] OP_BGTE  = 6'd25;
  localparam logic [5:0] OP_BLE   = 6'd26;
  localparam logic [5:0] OP_BLEQ  = 6'd27;
  localparam logic [5:0] OP_BLEU  = 6'd28;
  localparam logic [5:0] OP_BGTU  = 6'd29;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_HALT  = 6'd63;

endpackage

// File: rtl/instr_field_pack.sv
// rtl/instr_field_pack.sv - combinational map from op_sel and fields to one or two instruction words
module instr_field_pack
  import enc_pkg::*;
#(
  parameter int LI_SHORTEN = 1
) (
  input  logic [5:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [31:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word1,
  output logic [31:0] word2,
  output logic        two_words,
  output logic        illegal
);

  fmt_t       fmt;
  logic [5:0] code;
  logic [4:0] f_rs;
  logic [4:0] f_rt;
  logic [4:0] f_rd;
  logic [4:0] f_sh;

  always_comb begin
    fmt       = FMT_R;
    code      = 6'd0;
    f_rs      = rs;
    f_rt      = rt;
    f_rd      = rd;
    f_sh      = shamt;
    word1     = 32'd0;
    word2     = 32'd0;
    two_words = 1'b0;
    illegal   = 1'b0;

    // code holds funct for R-type and the primary opcode otherwise
    case (op_sel)
      ENC_ADD:   code = F_ADD;
      ENC_ADDU:  code = F_ADDU;
      ENC_SUB:   code = F_SUB;
      ENC_SUBU:  code = F_SUBU;
      ENC_MADD:  code = F_MADD;
      ENC_MADDU: code = F_MADDU;
      ENC_MUL:   code = F_MUL;
      ENC_AND:   code = F_AND;
      ENC_OR:    code = F_OR;
      ENC_XOR:   code = F_XOR;
      ENC_NOR:   code = F_NOR;
      ENC_SLT:   code = F_SLT;
      ENC_SLL:   begin code = F_SLL; f_rs = 5'd0; end
      ENC_SRL:   begin code = F_SRL; f_rs = 5'd0; end
      ENC_SRA:   begin code = F_SRA; f_rs = 5'd0; end
      ENC_SLA:   begin code = F_SLA; f_rs = 5'd0; end
      ENC_JR:    begin code = F_JR; f_rt = 5'd0; f_rd = 5'd0; f_sh = 5'd0; end
      ENC_MOVE:  begin code = F_ADDU; f_rt = 5'd0; f_sh = 5'd0; end
      ENC_ADDI:  begin fmt = FMT_I; code = OP_ADDI; end
      ENC_ADDIU: begin fmt = FMT_I; code = OP_ADDIU; end
      ENC_SLTI:  begin fmt = FMT_I; code = OP_SLTI; end
      ENC_SEQ:   begin fmt = FMT_I; code = OP_SEQ; end
      ENC_ANDI:  begin fmt = FMT_I; code = OP_ANDI; end
      ENC_ORI:   begin fmt = FMT_I; code = OP_ORI; end
      ENC_XORI:  begin fmt = FMT_I; code = OP_XORI; end
      ENC_LUI:   begin fmt = FMT_I; code = OP_LUI; f_rs = 5'd0; end
      ENC_LW:    begin fmt = FMT_I; code = OP_LW; end
      ENC_SW:    begin fmt = FMT_I; code = OP_SW; end
      ENC_BEQ:   begin fmt = FMT_I; code = OP_BEQ; end
      ENC_BNE:   begin fmt = FMT_I; code = OP_BNE; end
      ENC_BGT:   begin fmt = FMT_I; code = OP_BGT; end
      ENC_BGTE:  begin fmt = FMT_I; code = OP_BGTE; end
      ENC_BLE:   begin fmt = FMT_I; code = OP_BLE; end
      ENC_BLEQ:  begin fmt = FMT_I; code = OP_BLEQ; end
      ENC_BLEU:  begin fmt = FMT_I; code = OP_BLEU; end
      ENC_BGTU:  begin fmt = FMT_I; code = OP_BGTU; end
      ENC_J:     begin fmt = FMT_J; code = OP_J; end
      ENC_JAL:   begin fmt = FMT_J; code = OP_JAL; end
      ENC_HALT, ENC_LI, ENC_NOP: fmt = FMT_PSEUDO;
      default: begin fmt = FMT_PSEUDO; illegal = 1'b1; end
    endcase

    case (fmt)
      FMT_R: word1 = {6'd0, f_rs, f_rt, f_rd, f_sh, code};
      FMT_I: word1 = {code, f_rs, f_rt, imm[15:0]};
      FMT_J: word1 = {code, target};
      default: begin
        if (op_sel == ENC_HALT) begin
          word1 = {OP_HALT, 26'd0};
        end else if (op_sel == ENC_LI) begin
          // a zero half lets LI collapse to a single ORI or LUI
          if (LI_SHORTEN != 0 && imm[31:16] == 16'd0) begin
            word1 = {OP_ORI, 5'd0, rt, imm[15:0]};
          end else if (LI_SHORTEN != 0 && imm[15:0] == 16'd0) begin
            word1 = {OP_LUI, 5'd0, rt, imm[31:16]};
          end else begin
            word1     = {OP_LUI, 5'd0, rt, imm[31:16]};
            word2     = {OP_ORI, rt, rt, imm[15:0]};
            two_words = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - instruction encoder FSM and output register; INSTR_ENCODER_COUNT_EN adds word/error counters
module instr_encoder
  import enc_pkg::*;
#(
  parameter int LI_SHORTEN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [31:0] imm,
  input  logic [25:0] target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
`ifdef INSTR_ENCODER_COUNT_EN
  output logic        err,
  output logic [31:0] words_out,
  output logic [15:0] err_count
`else
  output logic        err
`endif
);

  state_t      state;
  logic [31:0] pending;
  logic [31:0] word1;
  logic [31:0] word2;
  logic        two_words;
  logic        illegal;
  logic        accept;

  instr_field_pack #(.LI_SHORTEN(LI_SHORTEN)) u_pack (
    .op_sel    (op_sel),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .imm       (imm),
    .target    (target),
    .word1     (word1),
    .word2     (word2),
    .two_words (two_words),
    .illegal   (illegal)
  );

  assign in_ready = (state == IDLE) | ((state == OUT1) & out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      pending   <= 32'd0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE, OUT1: begin
          if (accept) begin
            if (illegal) begin
              err       <= 1'b1;
              out_valid <= 1'b0;
              state     <= IDLE;
            end else begin
              out_instr <= word1;
              out_valid <= 1'b1;
              pending   <= word2;
              state     <= two_words ? OUT2A : OUT1;
            end
          end else if (state == OUT1 && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        OUT2A: begin
          if (out_ready) begin
            out_instr <= pending;
            state     <= OUT1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INSTR_ENCODER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      words_out <= 32'd0;
      err_count <= 16'd0;
    end else begin
      if (out_valid && out_ready) words_out <= words_out + 32'd1;
      if (accept && illegal && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
